// File: rtl/sd_rx_word_packer_pkg.sv
// sd_rx_word_packer_pkg: shared state encoding, sizing and byte-swap helper for the SD Rx word packer
package sd_rx_word_packer_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        PACK = 3'b010,
        DONE = 3'b100
    } state_e;
    localparam int BLK_NIBBLES_DEF = 1024;
    localparam int IDX_W = 3;
    localparam int CNT_W = 11;
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/sd_rx_word_hold.sv
// sd_rx_word_hold: single-entry holding register with pending flag, FIFO full handshake and sticky overflow
module sd_rx_word_hold
    import sd_rx_word_packer_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         clr_ovf,
    input  logic         load,
    input  logic [W-1:0] load_dat,
    input  logic         fifo_full,
    output logic [W-1:0] fifo_dat,
    output logic         fifo_we,
    output logic         overflow,
    output logic         pending_nxt
);
    logic [W-1:0] hold_q, hold_d;
    logic         pending_q, pending_d;
    logic         overflow_q, overflow_d;
    logic         drain;
    always_comb begin
        drain      = pending_q & ~fifo_full;
        hold_d     = hold_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (clr) begin
            pending_d  = 1'b0;
            overflow_d = clr_ovf ? 1'b0 : overflow_q;
        end else if (load && (!pending_q || drain)) begin
            hold_d    = load_dat;
            pending_d = 1'b1;
        end else if (load) begin
            overflow_d = 1'b1;
        end else if (drain) begin
            pending_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= '0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end
    assign fifo_dat    = hold_q;
    assign fifo_we     = pending_q & ~fifo_full;
    assign overflow    = overflow_q;
    assign pending_nxt = pending_d;
endmodule

// File: rtl/sd_rx_word_packer.sv
// sd_rx_word_packer: packs SD 4-bit read nibbles into 32-bit Rx FIFO words per block.
// Define SD_RX_BYTE_SWAP_EN to present bytes big-endian (first received byte in fifo_dat[31:24]).
module sd_rx_word_packer
    import sd_rx_word_packer_pkg::*;
#(
    parameter int BUS_W       = 4,
    parameter int WORD_W      = 32,
    parameter int BLK_NIBBLES = BLK_NIBBLES_DEF
) (
    input  logic              sd_clk,
    input  logic              rst,
    input  logic [BUS_W-1:0]  nib_in,
    input  logic              nib_we,
    input  logic              blk_start,
    input  logic              blk_abort,
    input  logic              fifo_full,
    output logic [WORD_W-1:0] fifo_dat,
    output logic              fifo_we,
    output logic              blk_done,
    output logic              overflow,
    output logic [7:0]        word_cnt
);
    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          nib_cnt_q, nib_cnt_d;
    logic [WORD_W-BUS_W-1:0]   part_q, part_d;
    logic [7:0]                word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0]         word_new;
    logic                      start, clr, accept, word_done, pend_nxt, cnt_full;
    always_comb begin
        start      = blk_start & ~blk_abort;
        clr        = blk_abort | start;
        cnt_full   = nib_cnt_q == CNT_W'(BLK_NIBBLES);
        accept     = (state_q == PACK) & nib_we & ~cnt_full;
        word_done  = accept & (&idx_q);
        // Nibbles shift in from the top so the first of a word ends at [3:0]
        part_d     = accept ? {nib_in, part_q[WORD_W-BUS_W-1:BUS_W]} : part_q;
`ifdef SD_RX_BYTE_SWAP_EN
        word_new   = byte_swap({nib_in, part_q});
`else
        word_new   = {nib_in, part_q};
`endif
        idx_d      = clr ? '0 : idx_q + IDX_W'(accept);
        nib_cnt_d  = clr ? '0 : nib_cnt_q + CNT_W'(accept);
        word_cnt_d = start ? '0 : word_cnt_q + 8'(fifo_we);
        state_d    = blk_abort ? IDLE :
                     start ? PACK :
                     (state_q == DONE) ? IDLE :
                     (state_q == PACK && cnt_full && !pend_nxt) ? DONE : state_q;
    end
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            nib_cnt_q  <= '0;
            part_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            nib_cnt_q  <= nib_cnt_d;
            part_q     <= part_d;
            word_cnt_q <= word_cnt_d;
        end
    end
    sd_rx_word_hold #(.W(WORD_W)) u_hold (
        .clk         (sd_clk),
        .rst         (rst),
        .clr         (clr),
        .clr_ovf     (start),
        .load        (word_done),
        .load_dat    (word_new),
        .fifo_full   (fifo_full),
        .fifo_dat    (fifo_dat),
        .fifo_we     (fifo_we),
        .overflow    (overflow),
        .pending_nxt (pend_nxt)
    );
    assign blk_done = state_q == DONE;
    assign word_cnt = word_cnt_q;
endmodule

// File: tb/tb_sd_rx_word_packer.sv
// tb_sd_rx_word_packer: directed self-checking bench for sd_rx_word_packer (honours SD_RX_BYTE_SWAP_EN)
module tb_sd_rx_word_packer;
    logic        sd_clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  nib_in = '0;
    logic        nib_we = 1'b0;
    logic        blk_start = 1'b0;
    logic        blk_abort = 1'b0;
    logic        fifo_full = 1'b0;
    logic [31:0] fifo_dat;
    logic        fifo_we;
    logic        blk_done;
    logic        overflow;
    logic [7:0]  word_cnt;
    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    logic [31:0] wq[$];

    always #5 sd_clk = ~sd_clk;

    sd_rx_word_packer dut (
        .sd_clk    (sd_clk),
        .rst       (rst),
        .nib_in    (nib_in),
        .nib_we    (nib_we),
        .blk_start (blk_start),
        .blk_abort (blk_abort),
        .fifo_full (fifo_full),
        .fifo_dat  (fifo_dat),
        .fifo_we   (fifo_we),
        .blk_done  (blk_done),
        .overflow  (overflow),
        .word_cnt  (word_cnt)
    );

    always @(negedge sd_clk) begin
        if (fifo_we === 1'b1) wq.push_back(fifo_dat);
        if (blk_done === 1'b1) done_cnt++;
    end

    function automatic logic [31:0] exp_w(input logic [31:0] w);
`ifdef SD_RX_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [31:0] q_at(input int i);
        return (wq.size() > i) ? wq[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic tick();
        @(posedge sd_clk);
        #1;
    endtask

    task automatic nib(input logic [3:0] v);
        nib_in = v;
        nib_we = 1'b1;
        tick();
        nib_we = 1'b0;
    endtask

    task automatic pulse_start();
        blk_start = 1'b1;
        tick();
        blk_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (fifo_we !== 1'b0) begin errors++; $display("FAIL reset fifo_we: got %b want 0", fifo_we); end
        checks++; if (fifo_dat !== 32'h0) begin errors++; $display("FAIL reset fifo_dat: got %h want 0", fifo_dat); end
        checks++; if (blk_done !== 1'b0) begin errors++; $display("FAIL reset blk_done: got %b want 0", blk_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b want 0", overflow); end
        checks++; if (word_cnt !== 8'd0) begin errors++; $display("FAIL reset word_cnt: got %0d want 0", word_cnt); end
    endtask

    task automatic test_full_block();
        int bad;
        wq.delete();
        done_cnt = 0;
        pulse_start();
        for (int k = 0; k < 1024; k++) nib(4'(k % 8 + 1));
        repeat (6) tick();
        bad = 0;
        foreach (wq[i]) if (wq[i] !== exp_w(32'h87654321)) bad++;
        checks++; if (wq.size() != 128) begin errors++; $display("FAIL block words: got %0d want 128", wq.size()); end
        checks++; if (bad != 0) begin errors++; $display("FAIL block data: %0d bad words, first %h want %h", bad, q_at(0), exp_w(32'h87654321)); end
        checks++; if (word_cnt !== 8'd128) begin errors++; $display("FAIL block word_cnt: got %0d want 128", word_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL block blk_done pulses: got %0d want 1", done_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL block overflow: got %b want 0", overflow); end
    endtask

    task automatic test_byte_order();
        logic [31:0] want;
`ifdef SD_RX_BYTE_SWAP_EN
        want = 32'h10325476;
`else
        want = 32'h76543210;
`endif
        wq.delete();
        pulse_start();
        for (int k = 0; k < 8; k++) nib(4'(k));
        repeat (2) tick();
        checks++; if (wq.size() != 1) begin errors++; $display("FAIL order count: got %0d want 1", wq.size()); end
        checks++; if (q_at(0) !== want) begin errors++; $display("FAIL order word: got %h want %h", q_at(0), want); end
    endtask

    task automatic test_backpressure();
        wq.delete();
        pulse_start();
        fifo_full = 1'b1;
        for (int k = 0; k < 16; k++) nib(4'(k + 1));
        repeat (3) tick();
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL bp held count: got %0d want 0", wq.size()); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp overflow: got %b want 1", overflow); end
        checks++; if (fifo_we !== 1'b0) begin errors++; $display("FAIL bp fifo_we while full: got %b want 0", fifo_we); end
        fifo_full = 1'b0;
        repeat (3) tick();
        checks++; if (wq.size() != 1) begin errors++; $display("FAIL bp release count: got %0d want 1", wq.size()); end
        checks++; if (q_at(0) !== exp_w(32'h87654321)) begin errors++; $display("FAIL bp release word: got %h want %h", q_at(0), exp_w(32'h87654321)); end
        checks++; if (word_cnt !== 8'd1) begin errors++; $display("FAIL bp word_cnt: got %0d want 1", word_cnt); end
    endtask

    task automatic test_abort();
        wq.delete();
        fifo_full = 1'b1;
        for (int k = 0; k < 13; k++) nib(4'hA);
        blk_abort = 1'b1;
        tick();
        blk_abort = 1'b0;
        fifo_full = 1'b0;
        repeat (3) tick();
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL abort fifo_we count: got %0d want 0", wq.size()); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL abort overflow held: got %b want 1", overflow); end
        checks++; if (word_cnt !== 8'd1) begin errors++; $display("FAIL abort word_cnt held: got %0d want 1", word_cnt); end
        for (int k = 0; k < 8; k++) nib(4'(k + 1));
        repeat (2) tick();
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL abort idle nibbles: got %0d words want 0", wq.size()); end
        pulse_start();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL abort start clears overflow: got %b want 0", overflow); end
        checks++; if (word_cnt !== 8'd0) begin errors++; $display("FAIL abort start clears word_cnt: got %0d want 0", word_cnt); end
        for (int k = 0; k < 8; k++) nib(4'(k + 1));
        repeat (2) tick();
        checks++; if (q_at(0) !== exp_w(32'h87654321) || wq.size() != 1) begin errors++; $display("FAIL abort repack: got %h (n=%0d) want %h", q_at(0), wq.size(), exp_w(32'h87654321)); end
    endtask

    task automatic test_gaps();
        wq.delete();
        pulse_start();
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 8; k++) begin
                nib(4'(k + 1));
                if (k == 7) begin
                    @(negedge sd_clk);
                    checks++; if (fifo_we !== 1'b1 || fifo_dat !== exp_w(32'h87654321)) begin errors++; $display("FAIL gaps word %0d: we=%b dat=%h want we=1 dat=%h", w, fifo_we, fifo_dat, exp_w(32'h87654321)); end
                    tick();
                    @(negedge sd_clk);
                    checks++; if (fifo_we !== 1'b0) begin errors++; $display("FAIL gaps single strobe %0d: got %b want 0", w, fifo_we); end
                    tick();
                end else begin
                    repeat (2) tick();
                end
            end
        end
        checks++; if (wq.size() != 2) begin errors++; $display("FAIL gaps count: got %0d want 2", wq.size()); end
    endtask

    task automatic test_back_to_back();
        wq.delete();
        pulse_start();
        fifo_full = 1'b1;
        for (int k = 0; k < 15; k++) nib(4'(k + 1));
        fifo_full = 1'b0;
        nib(4'h0);
        repeat (3) tick();
        checks++; if (wq.size() != 2) begin errors++; $display("FAIL b2b count: got %0d want 2", wq.size()); end
        checks++; if (q_at(0) !== exp_w(32'h87654321)) begin errors++; $display("FAIL b2b first: got %h want %h", q_at(0), exp_w(32'h87654321)); end
        checks++; if (q_at(1) !== exp_w(32'h0FEDCBA9)) begin errors++; $display("FAIL b2b second: got %h want %h", q_at(1), exp_w(32'h0FEDCBA9)); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b overflow: got %b want 0", overflow); end
        checks++; if (word_cnt !== 8'd2) begin errors++; $display("FAIL b2b word_cnt: got %0d want 2", word_cnt); end
    endtask

    task automatic test_rst_mid();
        pulse_start();
        for (int k = 0; k < 8; k++) nib(4'(k + 1));
        fifo_full = 1'b1;
        for (int k = 0; k < 18; k++) nib(4'(k + 3));
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rst pre overflow: got %b want 1", overflow); end
        rst = 1'b1;
        tick();
        checks++; if (fifo_dat !== 32'h0 || fifo_we !== 1'b0 || blk_done !== 1'b0) begin errors++; $display("FAIL rst outputs: dat=%h we=%b done=%b want 0/0/0", fifo_dat, fifo_we, blk_done); end
        checks++; if (overflow !== 1'b0 || word_cnt !== 8'd0) begin errors++; $display("FAIL rst flags: ovf=%b cnt=%0d want 0/0", overflow, word_cnt); end
        rst = 1'b0;
        fifo_full = 1'b0;
        wq.delete();
        for (int k = 0; k < 8; k++) nib(4'(k + 1));
        repeat (3) tick();
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL rst pending lost: got %0d words want 0", wq.size()); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_block();
        test_byte_order();
        test_backpressure();
        test_abort();
        test_gaps();
        test_back_to_back();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
